// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer for the 5-stage RV32 pipeline.
// Owns the PC, runs the instruction-memory req/ready handshake, loads the
// IF/ID register and applies M-stage redirects and ID back-pressure.
module fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCPlusImmM,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic            BranchM,
  input  logic            JtypeM,
  input  logic            StallD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PCD,
  output logic [31:0]     InstrD,
  output logic            ValidD,
  output logic            FlushE
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding at pc_q
    S_HOLD  = 2'd1,  // fetched word parked in the skid buffer, ID stalled
    S_DRAIN = 2'd2   // redirect arrived mid-request; wait out the old response
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_target_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [31:0]     skid_instr_q;
  logic [XLEN-1:0] pcd_q;
  logic [31:0]     instrd_q;
  logic            validd_q;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            fetch_valid_d;
  logic [XLEN-1:0] fetch_pc_d;
  logic [31:0]     fetch_instr_d;

  // Redirect decode: JALR target wins over branch/JAL target, always word aligned.
  always_comb begin
    redirect = BranchM | JtypeM;
    target   = (JtypeM ? ALUOutM : PCPlusImmM) & ~ALIGN_MASK;
  end

  // Instruction offered to IF/ID this cycle (only taken when ID is not stalled).
  always_comb begin
    fetch_valid_d = 1'b0;
    fetch_pc_d    = pc_q;
    fetch_instr_d = imem_rdata;
    case (state_q)
      S_FETCH: fetch_valid_d = imem_ready & ~redirect & ~StallD;
      S_HOLD: begin
        fetch_valid_d = ~redirect & ~StallD;
        fetch_pc_d    = skid_pc_q;
        fetch_instr_d = skid_instr_q;
      end
      default: fetch_valid_d = 1'b0;
    endcase
  end

  // Fetch FSM: PC, skid buffer and pending redirect target.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      skid_pc_q     <= '0;
      skid_instr_q  <= NOP_INSTR;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (redirect) begin
            if (imem_ready) begin
              pc_q <= target;
            end else begin
              // the in-flight request cannot be withdrawn, so finish it first
              pend_target_q <= target;
              state_q       <= S_DRAIN;
            end
          end else if (imem_ready) begin
            pc_q <= pc_q + PC_STEP;
            if (StallD) begin
              skid_pc_q    <= pc_q;
              skid_instr_q <= imem_rdata;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_q    <= target;
            state_q <= S_FETCH;
          end else if (!StallD) begin
            state_q <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (redirect) begin
            pend_target_q <= target;
          end
          if (imem_ready) begin
            // the newest redirect seen so far is the one that counts
            pc_q    <= redirect ? target : pend_target_q;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // IF/ID register: squash on redirect, hold on stall, otherwise load or bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcd_q    <= '0;
      instrd_q <= NOP_INSTR;
      validd_q <= 1'b0;
    end else if (redirect) begin
      instrd_q <= NOP_INSTR;
      validd_q <= 1'b0;
    end else if (!StallD) begin
      if (fetch_valid_d) begin
        pcd_q    <= fetch_pc_d;
        instrd_q <= fetch_instr_d;
        validd_q <= 1'b1;
      end else begin
        instrd_q <= NOP_INSTR;
        validd_q <= 1'b0;
      end
    end
  end

  assign imem_req  = reset & (state_q != S_HOLD);
  assign imem_addr = pc_q;
  assign FlushE    = reset & redirect;
  assign PCD       = pcd_q;
  assign InstrD    = instrd_q;
  assign ValidD    = validd_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized run against a
// cycle-level reference model of the fetch stage.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCPlusImmM, ALUOutM;
  logic        BranchM, JtypeM, StallD;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PCD, InstrD;
  logic        ValidD, FlushE;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_pc, m_pcd, m_instr, m_tgt, m_bpc, m_binstr;
  logic        m_valid, m_buffered, m_draining;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .PCPlusImmM (PCPlusImmM),
    .ALUOutM    (ALUOutM),
    .BranchM    (BranchM),
    .JtypeM     (JtypeM),
    .StallD     (StallD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCD        (PCD),
    .InstrD     (InstrD),
    .ValidD     (ValidD),
    .FlushE     (FlushE)
  );

  // instruction memory contents: address-tagged words, never equal to NOP in use
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ 32'hB00B_0003;
  endfunction

  // Reference: what the fetch stage does at one clock edge, given current inputs.
  task automatic model_step();
    logic        redir, got;
    logic [31:0] tgt, gpc, ginstr;
    redir  = BranchM | JtypeM;
    tgt    = (JtypeM ? ALUOutM : PCPlusImmM) & 32'hFFFF_FFFC;
    got    = 1'b0;
    gpc    = '0;
    ginstr = '0;
    if (!reset) begin
      m_pc = RESET_PC; m_buffered = 1'b0; m_draining = 1'b0; m_tgt = '0;
      m_valid = 1'b0; m_instr = NOP; m_pcd = '0;
      return;
    end
    if (m_buffered) begin
      if (redir) begin
        m_buffered = 1'b0; m_pc = tgt;
      end else if (!StallD) begin
        got = 1'b1; gpc = m_bpc; ginstr = m_binstr; m_buffered = 1'b0;
      end
    end else if (m_draining) begin
      if (redir) m_tgt = tgt;
      if (imem_ready) begin
        m_pc = m_tgt; m_draining = 1'b0;
      end
    end else if (imem_ready) begin
      if (redir) begin
        m_pc = tgt;
      end else begin
        if (StallD) begin
          m_buffered = 1'b1; m_bpc = m_pc; m_binstr = imem_rdata;
        end else begin
          got = 1'b1; gpc = m_pc; ginstr = imem_rdata;
        end
        m_pc = m_pc + 32'd4;
      end
    end else if (redir) begin
      m_draining = 1'b1; m_tgt = tgt;
    end
    if (redir) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (!StallD) begin
      m_valid = got;
      m_instr = got ? ginstr : NOP;
      if (got) m_pcd = gpc;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic br, input logic jt,
                       input logic st, input logic [31:0] pcimm, input logic [31:0] alu);
    reset = rst; imem_ready = rdy; BranchM = br; JtypeM = jt; StallD = st;
    PCPlusImmM = pcimm; ALUOutM = alu;
    imem_rdata = instr_at(imem_addr);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h80);
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_cmp++; if (FlushE !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", FlushE); end
    n_cmp++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ValidD); end
    n_cmp++; if (InstrD !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", InstrD, NOP); end
    n_cmp++; if (PCD !== 32'h0) begin n_fail++; $display("FAIL reset_pcd got %h want 0", PCD); end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL seq_addr c=%0d got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k)); end
      n_cmp++; if (ValidD !== (k >= 1)) begin
        n_fail++; $display("FAIL seq_valid c=%0d got %b want %b", k, ValidD, (k >= 1)); end
      if (k >= 1) begin
        n_cmp++; if (PCD !== 32'(4 * (k - 1)) || InstrD !== instr_at(32'(4 * (k - 1)))) begin
          n_fail++; $display("FAIL seq_ifid c=%0d got pcd=%h instr=%h want pcd=%h", k, PCD, InstrD, 32'(4 * (k - 1))); end
      end
      tick();
    end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    logic        e_req   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] e_addr  [8] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'hC, 32'h10};
    logic [31:0] e_pcd   [8] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8, 32'hC};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, (c >= 2 && c <= 4), 32'h0, 32'h0);
      @(negedge clk);
      n_cmp++; if (imem_req !== e_req[c]) begin
        n_fail++; $display("FAIL stall_req c=%0d got %b want %b", c, imem_req, e_req[c]); end
      if (e_req[c]) begin
        n_cmp++; if (imem_addr !== e_addr[c]) begin
          n_fail++; $display("FAIL stall_addr c=%0d got %h want %h", c, imem_addr, e_addr[c]); end
      end
      n_cmp++; if (ValidD !== (c >= 1)) begin
        n_fail++; $display("FAIL stall_valid c=%0d got %b want %b", c, ValidD, (c >= 1)); end
      if (c >= 1) begin
        n_cmp++; if (PCD !== e_pcd[c] || InstrD !== instr_at(e_pcd[c])) begin
          n_fail++; $display("FAIL stall_ifid c=%0d got pcd=%h instr=%h want pcd=%h", c, PCD, InstrD, e_pcd[c]); end
      end
      tick();
    end
    $display("test_stall done");
  endtask

  task automatic test_redirect();
    logic        br      [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        jt      [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] e_addr  [8] = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'h48, 32'h80, 32'h84};
    logic        e_valid [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_pcd   [8] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h40, 32'h44, 32'h0, 32'h80};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b1, br[c], jt[c], 1'b0, (c == 5) ? 32'h200 : 32'h40, 32'h82);
      @(negedge clk);
      n_cmp++; if (imem_addr !== e_addr[c]) begin
        n_fail++; $display("FAIL redir_addr c=%0d got %h want %h", c, imem_addr, e_addr[c]); end
      n_cmp++; if (FlushE !== (br[c] | jt[c])) begin
        n_fail++; $display("FAIL redir_flush c=%0d got %b want %b", c, FlushE, br[c] | jt[c]); end
      n_cmp++; if (ValidD !== e_valid[c]) begin
        n_fail++; $display("FAIL redir_valid c=%0d got %b want %b", c, ValidD, e_valid[c]); end
      if (e_valid[c]) begin
        n_cmp++; if (PCD !== e_pcd[c]) begin
          n_fail++; $display("FAIL redir_pcd c=%0d got %h want %h", c, PCD, e_pcd[c]); end
      end else begin
        n_cmp++; if (InstrD !== NOP) begin
          n_fail++; $display("FAIL redir_nop c=%0d got %h want %h", c, InstrD, NOP); end
      end
      tick();
    end
    $display("test_redirect done");
  endtask

  task automatic test_drain();
    logic        rdy     [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] e_addr  [7] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h100, 32'h104};
    logic        e_valid [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] e_pcd   [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, rdy[c], (c == 1), 1'b0, 1'b0, 32'h100, 32'h0);
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== e_addr[c]) begin
        n_fail++; $display("FAIL drain_addr c=%0d got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, e_addr[c]); end
      n_cmp++; if (ValidD !== e_valid[c]) begin
        n_fail++; $display("FAIL drain_valid c=%0d got %b want %b", c, ValidD, e_valid[c]); end
      if (e_valid[c]) begin
        n_cmp++; if (PCD !== e_pcd[c]) begin
          n_fail++; $display("FAIL drain_pcd c=%0d got %h want %h", c, PCD, e_pcd[c]); end
      end
      tick();
    end
    $display("test_drain done");
  endtask

  task automatic test_wrap();
    logic [31:0] e_addr [4] = '{32'h0, 32'hFFFF_FFFC, 32'h0, 32'h4};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, (c == 0), 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0);
      @(negedge clk);
      n_cmp++; if (imem_addr !== e_addr[c]) begin
        n_fail++; $display("FAIL wrap_addr c=%0d got %h want %h", c, imem_addr, e_addr[c]); end
      if (c == 2) begin
        n_cmp++; if (ValidD !== 1'b1 || PCD !== 32'hFFFF_FFFC) begin
          n_fail++; $display("FAIL wrap_pcd got valid=%b pcd=%h want valid=1 pcd=fffffffc", ValidD, PCD); end
      end
      tick();
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_in_drain();
    logic rst [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] e_addr [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(rst[c], rdy[c], (c <= 1), 1'b0, 1'b0, 32'h300, 32'h0);
      @(negedge clk);
      n_cmp++; if (imem_req !== rst[c]) begin
        n_fail++; $display("FAIL rstdrain_req c=%0d got %b want %b", c, imem_req, rst[c]); end
      n_cmp++; if (FlushE !== (rst[c] && c <= 1)) begin
        n_fail++; $display("FAIL rstdrain_flush c=%0d got %b want %b", c, FlushE, (rst[c] && c <= 1)); end
      if (rst[c]) begin
        n_cmp++; if (imem_addr !== e_addr[c]) begin
          n_fail++; $display("FAIL rstdrain_addr c=%0d got %h want %h", c, imem_addr, e_addr[c]); end
      end
      if (c >= 2) begin
        n_cmp++; if (ValidD !== (c >= 4) || (c >= 4 && PCD !== 32'(4 * (c - 4)))) begin
          n_fail++; $display("FAIL rstdrain_ifid c=%0d got valid=%b pcd=%h", c, ValidD, PCD); end
      end
      tick();
    end
    $display("test_reset_in_drain done");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(99) != 0);
      imem_ready = ($urandom_range(9) < 7);
      StallD     = ($urandom_range(3) == 0);
      BranchM    = ($urandom_range(11) == 0);
      JtypeM     = ($urandom_range(24) == 0);
      PCPlusImmM = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      ALUOutM    = $urandom;
      imem_rdata = $urandom;
      @(negedge clk);
      n_cmp++; if (imem_req !== (reset && !m_buffered)) begin
        n_fail++; $display("FAIL rnd_req i=%0d got %b want %b", i, imem_req, (reset && !m_buffered)); end
      if (reset && !m_buffered) begin
        n_cmp++; if (imem_addr !== m_pc) begin
          n_fail++; $display("FAIL rnd_addr i=%0d got %h want %h", i, imem_addr, m_pc); end
      end
      n_cmp++; if (FlushE !== (reset && (BranchM || JtypeM))) begin
        n_fail++; $display("FAIL rnd_flush i=%0d got %b want %b", i, FlushE, (reset && (BranchM || JtypeM))); end
      n_cmp++; if (ValidD !== m_valid || InstrD !== m_instr) begin
        n_fail++; $display("FAIL rnd_ifid i=%0d got valid=%b instr=%h want valid=%b instr=%h", i, ValidD, InstrD, m_valid, m_instr); end
      if (m_valid) begin
        n_cmp++; if (PCD !== m_pcd) begin
          n_fail++; $display("FAIL rnd_pcd i=%0d got %h want %h", i, PCD, m_pcd); end
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_drain();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
